// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory, decode and the branch unit.
// Handshakes: a request issues when o_imem_req && i_imem_ready; an instruction is consumed when
// o_inst_valid && i_inst_ready; i_imem_rvalid carries no ready and returns strictly in issue order.
interface fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  modport master (
    output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_imem_ready, i_imem_rvalid, i_imem_rdata, i_inst_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_imem_ready, i_imem_rvalid, i_imem_rdata, i_inst_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order word fetch with credit-limited outstanding requests,
// a PC tag queue matching responses to addresses, and an instruction FIFO feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] tag_wr;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   tag_pc    [DEPTH];

  logic [SW-1:0] credit_used;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] discard_on_redirect;
  logic          issue;
  logic          accept;
  logic          drop;
  logic          pop;
  logic          protocol_error;

  // Credit counts only registered state, so a pop in this cycle frees its slot next cycle.
  assign credit_used = SW'(count) + SW'(outstanding) + SW'(discard);
  assign bus.o_imem_req  = i_rst_n && !bus.i_redirect && (credit_used < SW'(DEPTH));
  assign bus.o_imem_addr = fetch_pc;

  assign issue  = bus.o_imem_req && bus.i_imem_ready;
  assign drop   = bus.i_imem_rvalid && (discard != '0);
  assign accept = bus.i_imem_rvalid && (discard == '0) && (outstanding != '0);
  assign protocol_error = i_rst_n && bus.i_imem_rvalid && (discard == '0) && (outstanding == '0);

  assign bus.o_inst_valid = (count != '0);
  assign bus.o_inst       = bus.o_inst_valid ? fifo_inst[fifo_rd] : 32'h0;
  assign bus.o_inst_pc    = bus.o_inst_valid ? fifo_pc[fifo_rd]   : 32'h0;
  assign pop              = bus.o_inst_valid && bus.i_inst_ready;

  // Every request still in flight at a redirect becomes stale; one arriving now is dropped now.
  assign in_flight           = discard + outstanding;
  assign discard_on_redirect = in_flight - CW'(bus.i_imem_rvalid && (in_flight != '0));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_ADDR;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else if (bus.i_redirect) begin
      fetch_pc    <= {bus.i_redirect_pc[31:2], 2'b00};
      count       <= '0;
      outstanding <= '0;
      discard     <= discard_on_redirect;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_wr   <= tag_wr + 1'b1;
      end
      if (accept) begin
        tag_rd  <= tag_rd + 1'b1;
        fifo_wr <= fifo_wr + 1'b1;
      end
      if (pop) begin
        fifo_rd <= fifo_rd + 1'b1;
      end
      if (drop) begin
        discard <= discard - 1'b1;
      end
      outstanding <= outstanding + CW'(issue) - CW'(accept);
      count       <= count + CW'(accept) - CW'(pop);
    end
  end

  // Storage needs no reset: the pointers and counters decide what is visible.
  always_ff @(posedge i_clk) begin
    if (issue) begin
      tag_pc[tag_wr] <= fetch_pc;
    end
    if (accept && !bus.i_redirect) begin
      fifo_inst[fifo_wr] <= bus.i_imem_rdata;
      fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!protocol_error)
        else $warning("imem response arrived with no fetch outstanding; data dropped");
      assert (credit_used <= SW'(DEPTH))
        else $error("fetch credit exceeded: count+outstanding+discard=%0d", credit_used);
    end
  end
`endif
endmodule
